// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO downstream of the UART receiver: edge-detected push, show-ahead pop.
// Optional registered interrupt output enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned IRQ_THRESH = 1
) (
  input  logic                  uart_clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_status,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  irq
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  rx_status_q;
  logic                  overflow_q, overflow_d;
  logic                  push_evt, do_push, do_pop, ovf_evt;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q];

  assign push_evt = rx_status & ~rx_status_q;
  assign do_pop   = rd_en & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push  = push_evt & (~full | do_pop);
  assign ovf_evt  = push_evt & full & ~do_pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_status_q <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      rx_status_q <= rx_status;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
    end
  end

  // Storage carries no reset; rd_data is masked to zero while empty.
  always_ff @(posedge uart_clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count_d >= CntW'(IRQ_THRESH)) | overflow_d;
    end
  end

  assign irq = irq_q;
`else
  // Threshold has no effect without interrupt support.
  assign irq = 1'b0 & (count_q >= CntW'(IRQ_THRESH));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DepthLog2 = 3;
  localparam int unsigned Depth     = 1 << DepthLog2;
  localparam int unsigned IrqThresh = 1;

  logic             uart_clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_status = 1'b0;
  logic             rd_en = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [7:0]       rd_data;
  logic             empty, full, overflow, irq;
  logic [DepthLog2:0] count;

  uart_rx_fifo #(
    .DEPTH_LOG2 (DepthLog2),
    .IRQ_THRESH (IrqThresh)
  ) dut (
    .uart_clk  (uart_clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .irq       (irq)
  );

  always #5 uart_clk = ~uart_clk;

  logic [7:0] m_q[$];
  bit         m_prev = 1'b1;
  bit         m_ovf  = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int unsigned n;
    bit          irq_exp;
    n = m_q.size();
`ifdef UART_RX_FIFO_IRQ_EN
    irq_exp = (n >= IrqThresh) || m_ovf;
`else
    irq_exp = 1'b0;
`endif
    check_eq("count", 32'(count), n);
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("full", 32'(full), 32'(n == Depth));
    check_eq("rd_data", 32'(rd_data), (n == 0) ? 32'h0 : 32'(m_q[0]));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("irq", 32'(irq), 32'(irq_exp));
  endtask

  // One clock edge of the reference: pop first so a full FIFO can accept a push.
  task automatic model_edge();
    bit evt, pop;
    evt    = rx_status && !m_prev;
    m_prev = rx_status;
    pop    = rd_en && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (ovf_clr) m_ovf = 1'b0;
    if (evt) begin
      if (m_q.size() < Depth) m_q.push_back(rx_data);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit rs, input logic [7:0] d, input bit rd, input bit clr);
    rx_status = rs;
    rx_data   = d;
    rd_en     = rd;
    ovf_clr   = clr;
    @(posedge uart_clk);
    model_edge();
    @(negedge uart_clk);
    check_model();
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b0, d, 1'b0, 1'b0);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit rs);
    reset     = 1'b0;
    rx_status = rs;
    rd_en     = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    m_q.delete();
    m_prev = 1'b1;
    m_ovf  = 1'b0;
    check_eq("reset_count", 32'(count), 0);
    check_eq("reset_empty", 32'(empty), 1);
    check_model();
    @(negedge uart_clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] cur;
    bit         rs;

    do_reset(1'b0);

    // Long-held rx_status yields exactly one push.
    step(1'b0, 8'hA5, 1'b0, 1'b0);
    repeat (20) step(1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("a5_count", 32'(count), 1);
    check_eq("a5_data", 32'(rd_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("a5_popped_empty", 32'(empty), 1);
    check_eq("a5_popped_data", 32'(rd_data), 0);

    // Fill, drain in order, then a push after pointer wrap.
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check_eq("fill_full", 32'(full), 1);
    check_eq("fill_count", 32'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_order", 32'(rd_data), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    push_byte(8'h55);
    check_eq("wrap_head", 32'(rd_data), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow drop, clear, and set-wins-over-clear.
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    push_byte(8'hFF);
    check_eq("ovf_set", 32'(overflow), 1);
    check_eq("ovf_count", 32'(count), 8);
    check_eq("ovf_head", 32'(rd_data), 32'h01);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("ovf_clr", 32'(overflow), 0);
    step(1'b0, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check_eq("ovf_set_wins", 32'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("fullrw_count", 32'(count), 8);
    check_eq("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("fullrw_tail", 32'(rd_data), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    check_eq("emptyrw_count", 32'(count), 1);
    check_eq("emptyrw_data", 32'(rd_data), 32'h99);

    // rx_status high across reset release; reset with bytes stored.
    do_reset(1'b1);
    repeat (3) step(1'b1, 8'h3C, 1'b0, 1'b0);
    check_eq("hi_at_release", 32'(count), 0);
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    check_eq("pre_reset_count", 32'(count), 5);
    do_reset(1'b1);
    repeat (3) step(1'b1, 8'h14, 1'b0, 1'b0);
    check_eq("no_repush", 32'(count), 0);

    // Random traffic; rx_data only changes while rx_status is low or rising.
    rs  = 1'b1;
    cur = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(rs);
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          rs = ~rs;
          if (rs) cur = 8'($urandom);
        end
        step(rs, cur, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
